smac_ctrl: RTL and testbench
============================

# smac_ctrl

Sequencer for one S_MAC datapath slice (DP_1x64 build). It accepts bit-plane beats from the activation/weight feeder through a valid/ready handshake. It drives every load, shift, clear, negate and valid strobe the slice consumes, and raises `out_valid` when the slice's `out_smac` holds a finished dot product. A tagged 6-stage control pipeline tracks each beat through the slice, so feeder stalls become bubbles and never corrupt accumulation.

## Interface
- `M`, 16, activation/weight vector width per beat.
- `Pa`, 8, activation precision in bits; legal range is Pa ≥ 2.
- `Pw`, 4, weight precision in bits; legal range is 2 ≤ Pw ≤ 4.
- `MNO`, 288, dot-product length. Derived `NCH = ceil(MNO/M)` chunks (18 at defaults).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: pulse that begins one dot product. Ignored while `busy`.
- `in_valid` in 1: feeder holds a valid act/wei bit-plane pair on the slice's `act`/`wei`.
- `in_ready` out 1: controller accepts a beat this cycle.
- `busy` out 1: a computation is in flight.
- `w_en_a`, `w_en_w`, `w_en_br`, `MSB_a` out 1 each: batch 0 controls.
- `w_en_ac1`, `s_en_ac1`, `cl_en_ac1`, `MSB_w`, `w_en_neg` out 1 each: batch 1 controls.
- `valid_ac2`, `s_en_ac2`, `cl_en_ac2` out 1 each: batch 2 controls.
- `sel_ac2_ac3` out 2: ac2/ac3 slot select.
- `valid_ac3`, `cl_en_ac3` out 1 each: batch 3 controls.
- `out_valid` out 1: single-cycle pulse; `out_smac` is final this cycle.

## Operation
- Beat order, MSB first:
  - Chunk `c` = 0..NCH-1 is the outer loop.
  - Weight bit `w` = Pw-1..0 is the middle loop.
  - Activation bit `a` = Pa-1..0 is the inner loop.
  - Total beats per computation: `B = NCH*Pw*Pa` (576 at defaults).
- Counters `a_cnt`, `w_cnt`, `ch_cnt` advance only on an accepted beat (`in_valid & in_ready`). Each counter wraps to its start value when its inner loop completes.
- `in_ready = busy & (accepted < B)`. The controller never stalls mid-run; the slice always absorbs one beat per cycle.
- Each accepted beat launches a tag `{a, w, c}` with a valid bit down stages S0..S6. Every stage strobe is gated by that stage's tag valid bit.
  - S0, accept cycle: `w_en_a = w_en_w = 1`. These are combinational from the handshake.
  - S1: `w_en_br = 1`; `MSB_a = (a == Pa-1)`.
  - S2: `w_en_ac1 = 1`.
    - If `a == Pa-1`: `cl_en_ac1 = 1`, `s_en_ac1 = 0` (load fresh).
    - Otherwise: `cl_en_ac1 = 0`, `s_en_ac1 = 1` (shift-accumulate).
  - S3, only if `a == 0`: `w_en_neg = 1`; `MSB_w = (w == Pw-1)`.
  - S4, only if `a == 0`: `valid_ac2 = 1`; `sel_ac2_ac3 = c[1:0]`.
    - If `w == Pw-1`: `cl_en_ac2 = 1`, `s_en_ac2 = 0`.
    - Otherwise: `cl_en_ac2 = 0`, `s_en_ac2 = 1`.
  - S5, only if `a == 0` and `w == 0`: `valid_ac3 = 1`; `sel_ac2_ac3 = c[1:0]`; `cl_en_ac3 = (c == 0)`.
  - S6, only if the tag is the final beat: `out_valid = 1`. `busy` drops on the following edge.
- `sel_ac2_ac3` muxing: S5 wins when `valid_ac3`, else S4. The two never collide because Pa ≥ 2 spaces successive S4 events at least 2 cycles apart. When neither stage is active, `sel_ac2_ac3` holds its last value.
- All strobes not listed for a stage are 0.

## Timing
- Reset values: every output is 0, all tags are invalid, all counters are 0. Reset takes effect asynchronously, including mid-run; the partial computation is abandoned and no `out_valid` is produced.
- `start` is sampled at edge T. `busy` and `in_ready` are high from T+1.
- A beat accepted in cycle K produces its S_n strobes in cycle K+n.
- `out_valid` occurs exactly 6 cycles after the final beat is accepted. `busy` is low the cycle after `out_valid`.
- A `start` in the same cycle as `out_valid` is ignored. A new `start` is accepted from the cycle `busy` is low.
- Bubbles: the feeder may deassert `in_valid` for any number of cycles. Strobes then appear only for real beats, and their order and flags are unchanged.

## Test plan
- Reset: assert `rst_n = 0` mid-run at beat 100 -> all outputs 0 immediately. After release, `busy = 0`. A new `start` completes normally with `out_valid` after exactly 576 beats + 6 cycles.
- Small config (M=16, Pa=2, Pw=2, MNO=32, so NCH=2), `in_valid` held high, `start` at cycle 0:
  - Beats are accepted in cycles 1..8; `out_valid` is at cycle 14.
  - `valid_ac3` fires at cycles 9 and 13, with `cl_en_ac3` = 1 then 0 and `sel_ac2_ac3` = 0 then 1.
- Defaults, continuous valid, `start` at cycle 0 -> 576 beats accepted in cycles 1..576; `out_valid` single pulse at cycle 582; 72 `valid_ac2` pulses; 18 `valid_ac3` pulses.
- Flags, defaults:
  - `MSB_a` is high on exactly every 8th `w_en_br` (the a=7 plane).
  - `cl_en_ac1` is high on those same beats, delayed 1 cycle.
  - `MSB_w` and `cl_en_ac2` are high on exactly every 4th `w_en_neg` / `valid_ac2` pulse respectively.
- Bubbles: `in_valid` alternates 1/0 -> `in_ready` is unaffected. All strobe sequences match the continuous run except for the spacing; `out_valid` comes 6 cycles after the last accept.
- `start` pulsed while `busy` -> no counter reset and no extra `out_valid`. The beat count for the run stays 576.

Source files
------------

// File: rtl/smac_ctrl_if.sv
// rtl/smac_ctrl_if.sv - feeder handshake plus slice strobe bundle driven by smac_ctrl
interface smac_ctrl_if;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic       busy;
    logic       w_en_a;
    logic       w_en_w;
    logic       w_en_br;
    logic       MSB_a;
    logic       w_en_ac1;
    logic       s_en_ac1;
    logic       cl_en_ac1;
    logic       MSB_w;
    logic       w_en_neg;
    logic       valid_ac2;
    logic       s_en_ac2;
    logic       cl_en_ac2;
    logic [1:0] sel_ac2_ac3;
    logic       valid_ac3;
    logic       cl_en_ac3;
    logic       out_valid;

    modport master (
        output start, in_valid,
        input  in_ready, busy, w_en_a, w_en_w, w_en_br, MSB_a,
        input  w_en_ac1, s_en_ac1, cl_en_ac1, MSB_w, w_en_neg,
        input  valid_ac2, s_en_ac2, cl_en_ac2, sel_ac2_ac3,
        input  valid_ac3, cl_en_ac3, out_valid
    );

    modport slave (
        input  start, in_valid,
        output in_ready, busy, w_en_a, w_en_w, w_en_br, MSB_a,
        output w_en_ac1, s_en_ac1, cl_en_ac1, MSB_w, w_en_neg,
        output valid_ac2, s_en_ac2, cl_en_ac2, sel_ac2_ac3,
        output valid_ac3, cl_en_ac3, out_valid
    );
endinterface

// File: rtl/smac_ctrl.sv
// rtl/smac_ctrl.sv - S_MAC slice sequencer: beat counters plus a tagged 6-stage strobe pipeline
module smac_ctrl #(
    parameter int M   = 16,
    parameter int Pa  = 8,
    parameter int Pw  = 4,
    parameter int MNO = 288
) (
    input  logic       clk,
    input  logic       rst_n,
    smac_ctrl_if.slave bus
);
    localparam int NCH = (MNO + M - 1) / M;
    localparam int B   = NCH * Pw * Pa;
    localparam int AW  = $clog2(Pa);
    localparam int WW  = $clog2(Pw);
    localparam int CW  = (NCH > 4) ? $clog2(NCH) : 2;
    localparam int BW  = $clog2(B + 1);
    localparam int NST = 6;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

    typedef struct packed {
        logic          vld;
        logic          last;
        logic [AW-1:0] a;
        logic [WW-1:0] w;
        logic [CW-1:0] c;
    } tag_t;

    state_t        state_q, state_d;
    logic [BW-1:0] acc_q, acc_d;
    logic [AW-1:0] a_cnt_q, a_cnt_d;
    logic [WW-1:0] w_cnt_q, w_cnt_d;
    logic [CW-1:0] ch_cnt_q, ch_cnt_d;
    logic [1:0]    sel_q, sel_d;
    tag_t          tag_q [1:NST];
    tag_t          tag_d [1:NST];

    logic accept;
    logic last_beat;
    logic s3_en, s4_en, s5_en;

    // RUN is left as soon as the final beat is taken, so RUN alone means accepted < B
    assign bus.in_ready = (state_q == ST_RUN);
    assign bus.busy     = (state_q != ST_IDLE);
    assign accept       = bus.in_valid & bus.in_ready;
    assign last_beat    = (acc_q == BW'(B - 1));

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        a_cnt_d  = a_cnt_q;
        w_cnt_d  = w_cnt_q;
        ch_cnt_d = ch_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d  = ST_RUN;
                    acc_d    = '0;
                    a_cnt_d  = AW'(Pa - 1);
                    w_cnt_d  = WW'(Pw - 1);
                    ch_cnt_d = '0;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    acc_d = acc_q + 1'b1;
                    if (a_cnt_q == '0) begin
                        a_cnt_d = AW'(Pa - 1);
                        if (w_cnt_q == '0) begin
                            w_cnt_d  = WW'(Pw - 1);
                            ch_cnt_d = (ch_cnt_q == CW'(NCH - 1)) ? '0 : ch_cnt_q + 1'b1;
                        end else begin
                            w_cnt_d = w_cnt_q - 1'b1;
                        end
                    end else begin
                        a_cnt_d = a_cnt_q - 1'b1;
                    end
                    if (last_beat) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (bus.out_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The pipeline never stalls: a feeder bubble simply enters as an invalid tag
    always_comb begin
        tag_d[1].vld  = accept;
        tag_d[1].last = last_beat;
        tag_d[1].a    = a_cnt_q;
        tag_d[1].w    = w_cnt_q;
        tag_d[1].c    = ch_cnt_q;
        for (int i = 2; i <= NST; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    always_comb begin
        s3_en = tag_q[3].vld & (tag_q[3].a == '0);
        s4_en = tag_q[4].vld & (tag_q[4].a == '0);
        s5_en = tag_q[5].vld & (tag_q[5].a == '0) & (tag_q[5].w == '0);

        bus.w_en_a    = accept;
        bus.w_en_w    = accept;
        bus.w_en_br   = tag_q[1].vld;
        bus.MSB_a     = tag_q[1].vld & (tag_q[1].a == AW'(Pa - 1));
        bus.w_en_ac1  = tag_q[2].vld;
        bus.cl_en_ac1 = tag_q[2].vld & (tag_q[2].a == AW'(Pa - 1));
        bus.s_en_ac1  = tag_q[2].vld & (tag_q[2].a != AW'(Pa - 1));
        bus.w_en_neg  = s3_en;
        bus.MSB_w     = s3_en & (tag_q[3].w == WW'(Pw - 1));
        bus.valid_ac2 = s4_en;
        bus.cl_en_ac2 = s4_en & (tag_q[4].w == WW'(Pw - 1));
        bus.s_en_ac2  = s4_en & (tag_q[4].w != WW'(Pw - 1));
        bus.valid_ac3 = s5_en;
        bus.cl_en_ac3 = s5_en & (tag_q[5].c == '0);
        bus.out_valid = tag_q[6].vld & tag_q[6].last;

        sel_d = s5_en ? tag_q[5].c[1:0] : (s4_en ? tag_q[4].c[1:0] : sel_q);
        bus.sel_ac2_ac3 = sel_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            a_cnt_q  <= '0;
            w_cnt_q  <= '0;
            ch_cnt_q <= '0;
            sel_q    <= '0;
            for (int i = 1; i <= NST; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            a_cnt_q  <= a_cnt_d;
            w_cnt_q  <= w_cnt_d;
            ch_cnt_q <= ch_cnt_d;
            sel_q    <= sel_d;
            for (int i = 1; i <= NST; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end
endmodule

// File: tb/tb_smac_ctrl.sv
// tb/tb_smac_ctrl.sv - bench for smac_ctrl: event-schedule reference model plus small-config timing
module tb_smac_ctrl;
    localparam int PA  = 8;
    localparam int PW  = 4;
    localparam int NCH = 18;
    localparam int B   = NCH * PW * PA;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    smac_ctrl_if bus ();
    smac_ctrl_if sbus ();

    smac_ctrl u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    smac_ctrl #(.M(16), .Pa(2), .Pw(2), .MNO(32)) u_small (.clk(clk), .rst_n(rst_n), .bus(sbus));

    typedef struct packed {
        logic br, msb_a, ac1, cl1, neg, msb_w, ac2, cl2;
        logic [1:0] sel4;
        logic ac3, cl3;
        logic [1:0] sel5;
        logic ov;
    } ev_t;

    ev_t        ring [8];
    int         total, bad, cyc, m_acc;
    logic       m_busy;
    logic [1:0] m_sel;
    int n_acc, n_br, n_msba, n_neg, n_msbw, n_ac2, n_cl2, n_ac3, n_ov, last_acc, ov_cyc;

    function automatic logic [18:0] obs_vec();
        return {bus.in_ready, bus.busy, bus.w_en_a, bus.w_en_w, bus.w_en_br, bus.MSB_a,
                bus.w_en_ac1, bus.s_en_ac1, bus.cl_en_ac1, bus.w_en_neg, bus.MSB_w,
                bus.valid_ac2, bus.s_en_ac2, bus.cl_en_ac2, bus.sel_ac2_ac3,
                bus.valid_ac3, bus.cl_en_ac3, bus.out_valid};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) ring[i] = '0;
        m_busy = 1'b0;
        m_acc  = 0;
        m_sel  = 2'd0;
    endfunction

    // Beat i (0-based) of a run, accepted in cycle k, books its downstream strobes
    function automatic void schedule(input int i, input int k);
        int a, w, c;
        a = PA - 1 - (i % PA);
        w = PW - 1 - ((i / PA) % PW);
        c = i / (PA * PW);
        ring[(k+1)%8].br    = 1'b1;
        ring[(k+1)%8].msb_a = (a == PA - 1);
        ring[(k+2)%8].ac1   = 1'b1;
        ring[(k+2)%8].cl1   = (a == PA - 1);
        if (a == 0) begin
            ring[(k+3)%8].neg   = 1'b1;
            ring[(k+3)%8].msb_w = (w == PW - 1);
            ring[(k+4)%8].ac2   = 1'b1;
            ring[(k+4)%8].cl2   = (w == PW - 1);
            ring[(k+4)%8].sel4  = 2'(c % 4);
        end
        if (a == 0 && w == 0) begin
            ring[(k+5)%8].ac3  = 1'b1;
            ring[(k+5)%8].cl3  = (c == 0);
            ring[(k+5)%8].sel5 = 2'(c % 4);
        end
        if (i == B - 1) ring[(k+6)%8].ov = 1'b1;
    endfunction

    task automatic check_cycle();
        ev_t         ev;
        logic        rdy, acc, busy_prev;
        logic [1:0]  sel;
        logic [18:0] exp;
        ev   = ring[cyc%8];
        rdy  = m_busy && (m_acc < B);
        acc  = bus.in_valid && rdy;
        sel  = ev.ac3 ? ev.sel5 : (ev.ac2 ? ev.sel4 : m_sel);
        exp  = {rdy, m_busy, acc, acc, ev.br, ev.msb_a, ev.ac1, ev.ac1 & ~ev.cl1, ev.cl1,
                ev.neg, ev.msb_w, ev.ac2, ev.ac2 & ~ev.cl2, ev.cl2, sel, ev.ac3, ev.cl3, ev.ov};
        chk($sformatf("strobes_cyc%0d", cyc), 32'(obs_vec()), 32'(exp));
        m_sel = sel;
        ring[cyc%8] = '0;
        n_br   += int'(bus.w_en_br);
        n_msba += int'(bus.MSB_a);
        n_neg  += int'(bus.w_en_neg);
        n_msbw += int'(bus.MSB_w);
        n_ac2  += int'(bus.valid_ac2);
        n_cl2  += int'(bus.cl_en_ac2);
        n_ac3  += int'(bus.valid_ac3);
        if (bus.out_valid) begin
            n_ov++;
            ov_cyc = cyc;
        end
        if (acc) begin
            schedule(m_acc, cyc);
            m_acc++;
            n_acc++;
            last_acc = cyc;
        end
        busy_prev = m_busy;
        if (ev.ov) m_busy = 1'b0;
        if (bus.start && !busy_prev) begin
            m_busy = 1'b1;
            m_acc  = 0;
        end
    endtask

    task automatic step(input logic iv, input logic st);
        bus.in_valid = iv;
        bus.start    = st;
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // mode 0: continuous, 1: alternating bubbles, 2: random bubbles and stray starts
    task automatic run(input int mode, input int abort_at);
        int   n;
        logic iv, st;
        n_acc = 0; n_br = 0; n_msba = 0; n_neg = 0; n_msbw = 0;
        n_ac2 = 0; n_cl2 = 0; n_ac3 = 0; n_ov = 0; last_acc = 0; ov_cyc = 0;
        step(1'b1, 1'b1);
        n = 0;
        while (m_busy && n < 4000 && !(abort_at >= 0 && m_acc >= abort_at)) begin
            case (mode)
                0:       iv = 1'b1;
                1:       iv = ((n % 2) == 0);
                default: iv = ($urandom_range(0, 2) != 0);
            endcase
            st = (mode == 2) && (ring[cyc%8].ov || ($urandom_range(0, 40) == 0));
            step(iv, st);
            n++;
        end
    endtask

    task automatic run_checks(input string name);
        step(1'b1, 1'b0);
        chk({name, "_busy_after"}, 32'(bus.busy), 32'd0);
        chk({name, "_beats"}, n_acc, B);
        chk({name, "_out_valid_count"}, n_ov, 1);
        chk({name, "_out_valid_latency"}, ov_cyc - last_acc, 6);
        chk({name, "_br_count"}, n_br, B);
        chk({name, "_msb_a_count"}, n_msba, B / PA);
        chk({name, "_ac2_count"}, n_ac2, NCH * PW);
        chk({name, "_cl2_count"}, n_cl2, NCH);
        chk({name, "_neg_count"}, n_neg, NCH * PW);
        chk({name, "_msb_w_count"}, n_msbw, NCH);
        chk({name, "_ac3_count"}, n_ac3, NCH);
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0;
        model_reset();
        rst_n = 1'b0;
        bus.start = 1'b0;  bus.in_valid = 1'b0;
        sbus.start = 1'b0; sbus.in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 32'(obs_vec()), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        sbus.start = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            chk($sformatf("small_c%0d", k), 32'({sbus.in_ready, sbus.busy, sbus.valid_ac3, sbus.out_valid}),
                32'({(k >= 1 && k <= 8), (k >= 1 && k <= 14), (k == 9 || k == 13), (k == 14)}));
            if (k == 9)  chk("small_ac3_first",  32'({sbus.cl_en_ac3, sbus.sel_ac2_ac3}), 32'b100);
            if (k == 13) chk("small_ac3_second", 32'({sbus.cl_en_ac3, sbus.sel_ac2_ac3}), 32'b001);
            @(posedge clk);
            #1;
            sbus.start = 1'b0;
        end

        run(0, -1);
        run_checks("cont");

        run(0, 100);
        rst_n = 1'b0;
        #2;
        chk("midrun_reset_outputs", 32'(obs_vec()), 32'd0);
        model_reset();
        for (int i = 0; i < 8; i++) ring[i] = '0;
        @(posedge clk);
        #1;
        cyc++;
        step(1'b1, 1'b0);
        rst_n = 1'b1;
        repeat (8) step(1'b1, 1'b0);

        run(0, -1);
        run_checks("after_reset");
        run(1, -1);
        run_checks("alternate");
        run(2, -1);
        run_checks("random_a");
        run(2, -1);
        run_checks("random_b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
